// File: rtl/spi_reg_pkg.sv
// ============================================================================
// Module : spi_reg_pkg
// Brief  : Shared constants and FSM state type for the SPI register peripheral.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_reg_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
    localparam int MAX_ADDR   = 4;
    localparam int NUM_REGS   = MAX_ADDR + 1;

    localparam int ADDR_EN_OUT_7_0  = 'h00;
    localparam int ADDR_EN_OUT_15_8 = 'h01;
    localparam int ADDR_EN_PWM_7_0  = 'h02;
    localparam int ADDR_EN_PWM_15_8 = 'h03;
    localparam int ADDR_PWM_DUTY    = 'h04;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_e;

endpackage : spi_reg_pkg

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module : spi_sync_edge
// Brief  : Multi-flop synchronizer with history flop and rise/fall detection.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;
    logic [STAGES:0]   prime_q;

    // Edges stay masked until the chain holds only post-reset samples, so an
    // input already away from its idle level at reset release is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= {STAGES{RESET_VAL}};
            hist_q  <= RESET_VAL;
            prime_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d_i};
            hist_q  <= sync_q[STAGES-1];
            prime_q <= {prime_q[STAGES-1:0], 1'b1};
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = prime_q[STAGES] &  sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = prime_q[STAGES] & ~sync_q[STAGES-1] &  hist_q;

endmodule : spi_sync_edge

`default_nettype wire

// File: rtl/spi_reg_peripheral.sv
// ============================================================================
// Module : spi_reg_peripheral
// Brief  : SPI mode-0 write-only slave owning the PWM control register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle
);

    localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl,  ncs_rise,  ncs_fall;
    logic w_unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi),
        .level_o(copi_lvl), .rise_o(copi_rise), .fall_o(copi_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs),
        .level_o(ncs_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    assign w_unused_sync = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};

    spi_state_e             state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [DATA_W-1:0]      regs_d [NUM_REGS];

    logic [ADDR_W-1:0]      w_addr;
    logic [DATA_W-1:0]      w_data;
    logic                   w_frame_ok;

    assign w_addr     = shift_q[FRAME_BITS-2 -: ADDR_W];
    assign w_data     = shift_q[DATA_W-1:0];
    assign w_frame_ok = (cnt_q == CNT_FULL) && shift_q[FRAME_BITS-1]
                        && (w_addr <= ADDR_W'(MAX_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

    // An SCLK rise coinciding with the nCS rise belongs to no frame and is dropped.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_d = ST_RECV;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            ST_RECV: begin
                if (ncs_rise) begin
                    state_d = ST_COMMIT;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], copi_lvl};
                    if (cnt_q != CNT_SAT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_COMMIT: begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (w_frame_ok && (w_addr == ADDR_W'(i))) begin
                        regs_d[i] = w_data;
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_7_0];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_15_8];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_7_0];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_15_8];
    assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];

endmodule : spi_reg_peripheral

`default_nettype wire

// File: tb/tb_spi_reg_peripheral.sv
// ============================================================================
// Module : tb_spi_reg_peripheral
// Brief  : Self-checking bench: directed table, corner sequences, random frames.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_reg_peripheral;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       ncs   = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;

    always #5 clk = ~clk;

    spi_reg_peripheral #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle)
    );

    typedef struct {
        logic [31:0]     frame;
        int              nbits;
        logic [4:0][7:0] exp;
    } vec_t;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] model_regs [5];
    vec_t       tbl [6];

    task automatic wait_clk(input int n, input int phase);
        repeat (n) @(posedge clk);
        #(phase);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [4:0][7:0] exp);
        chk({tag, "/en_out_7_0"},  en_reg_out_7_0,  exp[0]);
        chk({tag, "/en_out_15_8"}, en_reg_out_15_8, exp[1]);
        chk({tag, "/en_pwm_7_0"},  en_reg_pwm_7_0,  exp[2]);
        chk({tag, "/en_pwm_15_8"}, en_reg_pwm_15_8, exp[3]);
        chk({tag, "/duty"},        pwm_duty_cycle,  exp[4]);
    endtask

    function automatic logic [4:0][7:0] model_vec();
        logic [4:0][7:0] v;
        for (int i = 0; i < 5; i++) v[i] = model_regs[i];
        return v;
    endfunction

    // Reference: a frame lands only if it is exactly 16 bits, a write, and addr <= 4.
    function automatic void model_frame(input logic [31:0] frame, input int nbits);
        logic [15:0] f;
        int          a;
        f = frame[15:0];
        a = int'(f[14:8]);
        if (nbits == 16 && f[15] && a <= 4) model_regs[a] = f[7:0];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
    endfunction

    function automatic vec_t mk(input logic [31:0] frame, input int nbits,
                                input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                                input logic [7:0] r3, input logic [7:0] r4);
        vec_t v;
        v.frame  = frame;
        v.nbits  = nbits;
        v.exp[0] = r0; v.exp[1] = r1; v.exp[2] = r2; v.exp[3] = r3; v.exp[4] = r4;
        return v;
    endfunction

    task automatic send_bit(input logic b, input int half, input int phase);
        copi = b;
        wait_clk(half, phase);
        sclk = 1'b1;
        wait_clk(half, phase);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] frame, input int nbits, input int half, input int phase);
        ncs = 1'b0;
        wait_clk(half, phase);
        for (int i = nbits - 1; i >= 0; i--) send_bit(frame[i], half, phase);
        wait_clk(half, phase);
        ncs = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        logic [31:0] f;
        int          nb, ph, sel;

        model_reset();
        // After the 0x80F0 latency test, the table starts from r0=F0.
        tbl[0] = mk(32'h84CC,  16, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hCC);
        tbl[1] = mk(32'h00AA,  16, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hCC);
        tbl[2] = mk(32'h85AA,  16, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hCC);
        tbl[3] = mk(32'h40BB,  15, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hCC);
        tbl[4] = mk(32'h18166, 17, 8'hF0, 8'h00, 8'h00, 8'h00, 8'hCC);
        tbl[5] = mk(32'h8155,  16, 8'hF0, 8'h55, 8'h00, 8'h00, 8'hCC);

        wait_clk(5, 1);
        chk_regs("reset", model_vec());
        rst_n = 1'b1;
        wait_clk(10, 1);
        chk_regs("idle", model_vec());

        // Latency: update on the 3rd edge after the first edge sampling nCS high.
        send_frame(32'h80F0, 16, 5, 1);
        wait_clk(3, 1);
        chk("latency_early", en_reg_out_7_0, 8'h00);
        wait_clk(1, 1);
        chk("latency_exact", en_reg_out_7_0, 8'hF0);
        model_frame(32'h80F0, 16);
        wait_clk(3, 1);
        chk_regs("first_write", model_vec());

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].frame, tbl[i].nbits, 5, 1);
            wait_clk(6, 1);
            model_frame(tbl[i].frame, tbl[i].nbits);
            chk_regs($sformatf("tbl%0d", i), tbl[i].exp);
        end

        send_frame(32'h8201, 16, 5, 1);
        wait_clk(3, 1);
        send_frame(32'h8302, 16, 5, 1);
        wait_clk(6, 1);
        model_frame(32'h8201, 16);
        model_frame(32'h8302, 16);
        chk_regs("b2b", model_vec());

        // Reset in the middle of a frame; the tail must not produce a write.
        w = 16'h80FF;
        ncs = 1'b0;
        wait_clk(5, 1);
        for (int i = 15; i >= 7; i--) send_bit(w[i], 5, 1);
        rst_n = 1'b0;
        model_reset();
        wait_clk(3, 1);
        chk_regs("midrst_in", model_vec());
        rst_n = 1'b1;
        for (int i = 6; i >= 0; i--) send_bit(w[i], 5, 1);
        wait_clk(5, 1);
        ncs = 1'b1;
        wait_clk(6, 1);
        chk_regs("midrst_tail", model_vec());
        send_frame(32'h8011, 16, 5, 1);
        wait_clk(6, 1);
        model_frame(32'h8011, 16);
        chk_regs("after_rst", model_vec());

        // Minimum SCLK timing with random clk phase, checked against the model.
        for (int k = 0; k < 24; k++) begin
            w[15]   = ($urandom_range(0, 4) != 0);
            w[14:8] = 7'($urandom_range(0, 6));
            w[7:0]  = 8'($urandom);
            sel     = int'($urandom_range(0, 9));
            ph      = int'($urandom_range(1, 9));
            if (sel == 0) begin
                nb = 15; f = {17'b0, w[15:1]};
            end else if (sel == 1) begin
                nb = 17; f = {15'b0, 1'($urandom), w};
            end else begin
                nb = 16; f = {16'b0, w};
            end
            send_frame(f, nb, 3, ph);
            wait_clk(6, ph);
            model_frame(f, nb);
            chk_regs($sformatf("rnd%0d", k), model_vec());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_spi_reg_peripheral

`default_nettype wire
